// File: rtl/laplacian_window_gen.sv
// Cross-shaped 5-tap window generator for a raster pixel stream.
// Ports: clk/rst; pix_in/in_valid/in_sof/in_ready in; p2,p4,p5,p6,p8/out_valid/out_ready out; frame_done.
module laplacian_window_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              in_valid,
  input  logic              in_sof,
  output logic              in_ready,
  output logic [DATA_W-1:0] p2,
  output logic [DATA_W-1:0] p4,
  output logic [DATA_W-1:0] p5,
  output logic [DATA_W-1:0] p6,
  output logic [DATA_W-1:0] p8,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_done
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [DATA_W-1:0] lb1_mem [IMG_WIDTH];
  logic [DATA_W-1:0] lb2_mem [IMG_WIDTH];

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;

  logic [DATA_W-1:0] lb1_rd, lb2_rd;
  // Previous samples: row-2 at c-1, row-1 at c-1 and c-2, row at c-1.
  logic [DATA_W-1:0] r2_1_q, r1_1_q, r1_2_q, r0_1_q;

  logic [DATA_W-1:0] p2_q, p4_q, p5_q, p6_q, p8_q;
  logic              ov_q, ov_d;
  logic              last_q, last_d;
  logic              fd_q, fd_d;

  logic accept, consume, load;

  assign in_ready = !ov_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = ov_q && out_ready;

  // sof forces the pixel to the frame origin whatever the counters say.
  assign cur_col = in_sof ? '0 : col_q;
  assign cur_row = in_sof ? '0 : row_q;

  assign lb1_rd = lb1_mem[cur_col];
  assign lb2_rd = lb2_mem[cur_col];

  assign load = accept && (cur_row >= ROW_TWO)
                       && (cur_col >= COL_TWO);

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    ov_d   = ov_q;
    last_d = last_q;
    fd_d   = consume && last_q;
    if (accept) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end
    if (load) begin
      ov_d   = 1'b1;
      last_d = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    end else if (consume) begin
      ov_d   = 1'b0;
      last_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb2_mem[cur_col] <= lb1_rd;
      lb1_mem[cur_col] <= pix_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      r2_1_q <= '0;
      r1_1_q <= '0;
      r1_2_q <= '0;
      r0_1_q <= '0;
      p2_q   <= '0;
      p4_q   <= '0;
      p5_q   <= '0;
      p6_q   <= '0;
      p8_q   <= '0;
      ov_q   <= 1'b0;
      last_q <= 1'b0;
      fd_q   <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      ov_q   <= ov_d;
      last_q <= last_d;
      fd_q   <= fd_d;
      if (accept) begin
        r2_1_q <= lb2_rd;
        r1_1_q <= lb1_rd;
        r1_2_q <= r1_1_q;
        r0_1_q <= pix_in;
      end
      if (load) begin
        p2_q <= r2_1_q;
        p4_q <= r1_2_q;
        p5_q <= r1_1_q;
        p6_q <= lb1_rd;
        p8_q <= r0_1_q;
      end
    end
  end

  assign p2         = p2_q;
  assign p4         = p4_q;
  assign p5         = p5_q;
  assign p6         = p6_q;
  assign p8         = p8_q;
  assign out_valid  = ov_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_laplacian_window_gen.sv
// Directed bench for laplacian_window_gen on a 5x4 frame.
// Checks windows, latency, backpressure, bubbles, resync and reset.
module tb_laplacian_window_gen;

  localparam int W = 5;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pix_in;
  logic       in_valid;
  logic       in_sof;
  logic       in_ready;
  logic [7:0] p2, p4, p5, p6, p8;
  logic       out_valid;
  logic       out_ready;
  logic       frame_done;

  laplacian_window_gen #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .DATA_W    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_in    (pix_in),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_ready  (in_ready),
    .p2        (p2),
    .p4        (p4),
    .p5        (p5),
    .p6        (p6),
    .p8        (p8),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  int          base;
  int          widx;
  int          fd_cnt;
  int          early_ov;
  logic [39:0] snap;
  logic [39:0] first_w;
  logic [39:0] last_w;

  function automatic logic [7:0] px(input int b, input int r, input int c);
    return 8'(b + 16 * r + c);
  endfunction

  function automatic logic [39:0] exp_win(input int b, input int idx);
    int r, c;
    r = 1 + idx / (W - 2);
    c = 1 + idx % (W - 2);
    return {px(b, r - 1, c), px(b, r, c - 1), px(b, r, c),
            px(b, r, c + 1), px(b, r + 1, c)};
  endfunction

  function automatic logic [39:0] cur_win();
    return {p2, p4, p5, p6, p8};
  endfunction

  task automatic chk(input string tag, input logic [39:0] obs,
                     input logic [39:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check what the upcoming edge consumes,
  // then advance to just after the edge.
  task automatic cyc(input logic v, input logic sof,
                     input logic [7:0] pix, input logic ordy,
                     output logic acc);
    in_valid  = v;
    in_sof    = sof;
    pix_in    = pix;
    out_ready = ordy;
    #1;
    acc = v && in_ready;
    if (!ordy && out_valid) begin
      chk("stall_in_ready", 40'(in_ready), 40'(0));
      chk("stall_hold", cur_win(), snap);
    end
    if (out_valid && out_ready) begin
      if (widx < (W - 2) * (H - 2))
        chk($sformatf("win%0d", widx), cur_win(), exp_win(base, widx));
      else
        chk("extra_window", 40'(widx), 40'((W - 2) * (H - 2) - 1));
      if (widx == 0) first_w = cur_win();
      last_w = cur_win();
      widx++;
    end
    @(posedge clk);
    #1;
    if (frame_done) fd_cnt++;
  endtask

  task automatic run_frame(input int b, input bit bubbles, input int stall);
    int   pi, t, stall_left;
    logic acc, ordy, v;
    base       = b;
    widx       = 0;
    fd_cnt     = 0;
    early_ov   = 0;
    pi         = 0;
    t          = 0;
    stall_left = stall;
    while (pi < W * H && t < 400) begin
      v    = bubbles ? (t % 2 == 0) : 1'b1;
      ordy = 1'b1;
      if (stall_left > 0 && out_valid) begin
        if (stall_left == stall) snap = cur_win();
        ordy = 1'b0;
        stall_left--;
      end
      cyc(v, (pi == 0), px(b, pi / W, pi % W), ordy, acc);
      if (acc) pi++;
      if (pi < 13 && out_valid) early_ov++;
      if (acc && pi == 13) begin
        chk("lat_valid", 40'(out_valid), 40'(1));
        chk("lat_p5", 40'(p5), 40'(px(b, 1, 1)));
      end
      t++;
    end
    chk("all_px_accepted", 40'(pi), 40'(W * H));
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1, acc);
    end
    chk("no_early_valid", 40'(early_ov), 40'(0));
    chk("win_count", 40'(widx), 40'((W - 2) * (H - 2)));
    chk("frame_done_cnt", 40'(fd_cnt), 40'(1));
    chk("drained", 40'(out_valid), 40'(0));
  endtask

  initial begin
    logic acc;
    rst       = 1'b1;
    pix_in    = '0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    out_ready = 1'b1;
    base      = 0;
    widx      = 0;
    fd_cnt    = 0;
    snap      = '0;
    first_w   = '0;
    last_w    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_windows", cur_win(), 40'h0);
    chk("rst_out_valid", 40'(out_valid), 40'(0));
    chk("rst_frame_done", 40'(frame_done), 40'(0));
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 40'(in_ready), 40'(1));

    run_frame(0, 1'b0, 0);
    chk("basic_first", first_w, {8'd1, 8'd16, 8'd17, 8'd18, 8'd33});
    chk("basic_last", last_w, {8'd19, 8'd34, 8'd35, 8'd36, 8'd51});

    run_frame(0, 1'b0, 3);
    chk("bp_first", first_w, {8'd1, 8'd16, 8'd17, 8'd18, 8'd33});

    run_frame(0, 1'b1, 0);
    chk("bub_last", last_w, {8'd19, 8'd34, 8'd35, 8'd36, 8'd51});

    run_frame(200, 1'b0, 0);
    chk("resync_p5", 40'(first_w[23:16]), 40'(217));

    base = 0;
    widx = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, (i == 0), px(0, i / W, i % W), 1'b1, acc);
    end
    rst = 1'b1;
    #1;
    chk("midrst_valid", 40'(out_valid), 40'(0));
    chk("midrst_p5", 40'(p5), 40'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    run_frame(0, 1'b0, 0);
    chk("post_rst_p5", 40'(first_w[23:16]), 40'(17));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
